dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 31 +++
 rtl/arb_timeout_counter.sv | 39 +++
 rtl/dmem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, grant encoding
// and the IDLE-state arbitration rule.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    LDR_BUSY = 2'd2,
    CPU_DONE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LDR  = 2'd2
  } grant_e;

  function automatic logic is_busy(input arb_state_e s);
    return (s == CPU_BUSY) || (s == LDR_BUSY);
  endfunction

  // The loader wins when the CPU is quiet or the loader has been starved.
  function automatic grant_e arbitrate(input logic cpu_req,
                                       input logic ldr_pending,
                                       input logic starved);
    if (ldr_pending && (!cpu_req || starved)) return GNT_LDR;
    if (cpu_req) return GNT_CPU;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th cycle; reusable for any req/ack memory port.
module arb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_reg;
  logic [CNT_W-1:0] tmo_cnt_next;

  assign expire = (tmo_cnt_reg == CNT_LAST);

  // Holds at the last value so expiry stays visible until the next clear.
  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    if (clr) begin
      tmo_cnt_next = '0;
    end else if (en && !expire) begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Sequences the single-port data memory between the pipeline MEM stage and
// the loader port, with loader starvation control and a timeout watchdog.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LDR_MAX_WAIT = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_valid,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ready,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  input  logic              err_clr
);

  localparam int STARVE_W = $clog2(LDR_MAX_WAIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(LDR_MAX_WAIT);

  arb_state_e          state_reg, state_next;
  logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic                mem_req_reg, mem_req_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0]   cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_W-1:0]   ldr_rdata_reg, ldr_rdata_next;
  logic                ldr_ready_reg, ldr_ready_next;
  logic                err_reg, err_next;

  grant_e grant;
  logic   cpu_req;
  logic   ldr_pending;
  logic   starved;
  logic   busy;
  logic   done;
  logic   abort;
  logic   set_err;
  logic   tmo_expire;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign cpu_stall = cpu_req & (state_reg != CPU_DONE);

  // The loader keeps ldr_valid up through its ldr_ready cycle; masking it
  // there stops the finished request from being granted a second time.
  assign ldr_pending = ldr_valid & ~ldr_ready_reg;
  assign starved     = (starve_cnt_reg == STARVE_MAX);
  assign grant       = (state_reg == IDLE) ? arbitrate(cpu_req, ldr_pending, starved)
                                           : GNT_NONE;

  assign busy  = is_busy(state_reg);
  assign done  = busy & mem_ack;
  assign abort = busy & ~mem_ack & tmo_expire;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant != GNT_NONE),
    .en     (busy & ~mem_ack),
    .expire (tmo_expire)
  );

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    cpu_rdata_next  = cpu_rdata_reg;
    ldr_rdata_next  = ldr_rdata_reg;
    ldr_ready_next  = 1'b0;
    set_err         = 1'b0;

    if (!ldr_pending) begin
      starve_cnt_next = '0;
    end

    case (state_reg)
      IDLE: begin
        if (grant == GNT_LDR) begin
          state_next      = LDR_BUSY;
          mem_req_next    = 1'b1;
          mem_we_next     = ldr_we;
          mem_addr_next   = ldr_addr;
          mem_wdata_next  = ldr_wdata;
          starve_cnt_next = '0;
        end else if (grant == GNT_CPU) begin
          // A simultaneous read+write request is carried out as a write.
          state_next     = CPU_BUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = cpu_wr;
          mem_addr_next  = cpu_addr;
          mem_wdata_next = cpu_wdata;
          set_err        = cpu_rd & cpu_wr;
          if (ldr_pending && !starved) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
          end
        end
      end

      CPU_BUSY, LDR_BUSY: begin
        if (done || abort) begin
          mem_req_next = 1'b0;
          set_err      = abort;
          if (state_reg == CPU_BUSY) begin
            state_next = CPU_DONE;
            if (abort) begin
              cpu_rdata_next = '0;
            end else if (!mem_we_reg) begin
              cpu_rdata_next = mem_rdata;
            end
          end else begin
            state_next     = IDLE;
            ldr_ready_next = 1'b1;
            if (abort) begin
              ldr_rdata_next = '0;
            end else if (!mem_we_reg) begin
              ldr_rdata_next = mem_rdata;
            end
          end
        end
      end

      CPU_DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    err_next = set_err | (err_reg & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      cpu_rdata_reg  <= '0;
      ldr_rdata_reg  <= '0;
      ldr_ready_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      cpu_rdata_reg  <= cpu_rdata_next;
      ldr_rdata_reg  <= ldr_rdata_next;
      ldr_ready_reg  <= ldr_ready_next;
      err_reg        <= err_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign ldr_rdata = ldr_rdata_reg;
  assign ldr_ready = ldr_ready_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random
// CPU/loader traffic against a behavioural memory and reference model.
module tb_dmem_port_arbiter;

  localparam int TIMEOUT_CYC = 64;
  localparam int MAX_WAIT    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ldr_valid = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic        ldr_ready;
  logic [31:0] ldr_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Responder controls and activity counters
  int   ack_lat = 1;
  bit   ack_en = 1'b1;
  logic manual_ack = 1'b0;
  int   req_age = 0;
  int   txn_cnt = 0;
  int   req_hi = 0;
  int   stall_cnt = 0;
  int   rdy_cnt = 0;

  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] exp_cpu_rdata = '0;

  dmem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .LDR_MAX_WAIT (MAX_WAIT),
    .TIMEOUT      (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ldr_valid (ldr_valid),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_ready (ldr_ready),
    .ldr_rdata (ldr_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Variable-latency memory: acks in the ack_lat-th cycle of a request.
  always @(posedge clk) begin
    #2;
    if (mem_req) req_age = req_age + 1;
    else         req_age = 0;
    if (mem_req && ack_en && req_age == ack_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = phys_rd(mem_addr);
      if (mem_we) phys_mem[mem_addr] = mem_wdata;
      txn_cnt   = txn_cnt + 1;
    end else begin
      mem_ack   = manual_ack;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (mem_req)   req_hi    = req_hi + 1;
    if (cpu_stall) stall_cnt = stall_cnt + 1;
    if (ldr_ready) rdy_cnt   = rdy_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input logic clr,
                        input bit expect_abort);
    int s0, r0, t0, exp_cyc;
    bit seen;
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    ack_lat = lat; err_clr = clr;
    s0 = stall_cnt; r0 = req_hi; t0 = txn_cnt; seen = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1) err_clr = 1'b0;
      if (mem_req) begin
        check("payload_addr", 64'(mem_addr), 64'(a));
        check("payload_we_data", 64'({mem_we, mem_wdata}), 64'({wr, d}));
      end
      if (!cpu_stall) begin
        seen = 1'b1;
        break;
      end
    end
    err_clr = 1'b0;
    check("cpu_done_seen", 64'(seen), 64'd1);
    exp_cyc = expect_abort ? TIMEOUT_CYC : lat;
    if (expect_abort) exp_cpu_rdata = '0;
    else if (wr)      ref_mem[a] = d;
    else              exp_cpu_rdata = ref_rd(a);
    check("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu_rdata));
    check("stall_cycles", 64'(stall_cnt - s0), 64'(exp_cyc + 1));
    check("req_cycles", 64'(req_hi - r0), 64'(exp_cyc));
    check("mem_txns", 64'(txn_cnt - t0), expect_abort ? 64'd0 : 64'd1);
    $display("cpu rd=%0b wr=%0b addr=%08h wdata=%08h lat=%0d rdata=%08h err=%0b",
             rd, wr, a, d, lat, cpu_rdata, err);
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic ldr_op(input logic we, input logic [31:0] a, input logic [31:0] d, input int lat);
    int k0;
    bit seen;
    @(posedge clk); #1;
    ldr_valid = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d; ack_lat = lat;
    k0 = rdy_cnt; seen = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk); #1;
      if (ldr_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("ldr_ready_seen", 64'(seen), 64'd1);
    if (we) ref_mem[a] = d;
    else    check("ldr_rdata", 64'(ldr_rdata), 64'(ref_rd(a)));
    $display("ldr we=%0b addr=%08h wdata=%08h lat=%0d rdata=%08h", we, a, d, lat, ldr_rdata);
    @(posedge clk); #1;
    ldr_valid = 1'b0;
    @(negedge clk); #1;
    check("ldr_ready_pulse", 64'(rdy_cnt - k0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cpu_grants, ldr_at, k0;
    bit prev_req, ldr_seen;
    logic [31:0] a, d;
    int kind, lat;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_payload", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
    check("rst_rdata", 64'({cpu_rdata, ldr_rdata}), 64'd0);
    check("rst_flags", 64'({ldr_ready, err, cpu_stall}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // CPU load, ack in the second request cycle
    phys_mem[32'h40] = 32'h1234_5678;
    ref_mem[32'h40]  = 32'h1234_5678;
    cpu_op(1'b1, 1'b0, 32'h40, 32'h0, 2, 1'b0, 1'b0);
    check("load_literal", 64'(cpu_rdata), 64'h1234_5678);

    // CPU store, ack in the first request cycle
    cpu_op(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    check("store_mem", 64'(phys_rd(32'h80)), 64'hCAFE_F00D);

    // Loader starvation: CPU requests continuously, loader waits
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
    ldr_valid = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h200; ldr_wdata = 32'h5A5A_0001;
    ack_lat = 1;
    cpu_grants = 0; ldr_at = -1; prev_req = 1'b0; ldr_seen = 1'b0; k0 = rdy_cnt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk); #1;
      if (mem_req && !prev_req) begin
        if (mem_we && mem_addr == 32'h200) ldr_at = cpu_grants;
        else                               cpu_grants++;
      end
      prev_req = mem_req;
      if (ldr_ready) begin
        ldr_seen = 1'b1;
        break;
      end
    end
    check("starve_ldr_done", 64'(ldr_seen), 64'd1);
    check("starve_cpu_grants", 64'(ldr_at), 64'(MAX_WAIT));
    check("starve_cnt_after", 64'(dut.starve_cnt_reg), 64'd0);
    $display("starve cpu_grants_before_loader=%0d", ldr_at);
    @(posedge clk); #1;
    ldr_valid = 1'b0; cpu_rd = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("starve_ready_pulses", 64'(rdy_cnt - k0), 64'd1);
    check("starve_ldr_write", 64'(phys_rd(32'h200)), 64'h5A5A_0001);
    ref_mem[32'h200] = 32'h5A5A_0001;

    // Timeout: no ack ever
    ack_en = 1'b0;
    cpu_op(1'b1, 1'b0, 32'h44, 32'h0, 1, 1'b0, 1'b1);
    check("tmo_err", 64'(err), 64'd1);
    ack_en = 1'b1;
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk); #1;
    check("err_cleared", 64'(err), 64'd0);

    // Read+write together: performed as write, err set despite err_clr
    cpu_op(1'b1, 1'b1, 32'h48, 32'h0BAD_0BAD, 2, 1'b1, 1'b0);
    check("rdwr_err", 64'(err), 64'd1);
    check("rdwr_mem", 64'(phys_rd(32'h48)), 64'h0BAD_0BAD);

    // Random traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      a    = 32'h300 + 32'($urandom_range(0, 7)) * 4;
      d    = $urandom;
      lat  = int'($urandom_range(1, 4));
      case (kind)
        0:       cpu_op(1'b1, 1'b0, a, d, lat, 1'b0, 1'b0);
        1:       cpu_op(1'b0, 1'b1, a, d, lat, 1'b0, 1'b0);
        2:       ldr_op(1'b0, a, d, lat);
        default: ldr_op(1'b1, a, d, lat);
      endcase
    end

    // Reset during a loader transaction
    cpu_op(1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b0, 1'b0);
    ldr_op(1'b0, 32'h40, 32'h0, 1);
    ack_en = 1'b0;
    @(posedge clk); #1;
    ldr_valid = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h44;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_req", 64'(mem_req), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_payload", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
    check("midrst_rdata", 64'({cpu_rdata, ldr_rdata}), 64'd0);
    check("midrst_flags", 64'({ldr_ready, err}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; ldr_valid = 1'b0;
    k0 = rdy_cnt;
    manual_ack = 1'b1;
    @(posedge clk); #3;
    manual_ack = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); #1;
      check("late_ack_req", 64'({mem_req, cpu_stall}), 64'd0);
      check("late_ack_ldr", 64'({ldr_ready, ldr_rdata}), 64'd0);
      check("late_ack_err", 64'(err), 64'd0);
    end
    check("late_ack_pulses", 64'(rdy_cnt - k0), 64'd0);
    ack_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
